// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, widths and pointer helper for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int CNT_W   = 8;
  localparam int PTR_W   = 3;
  localparam int BURST_W = 4;

  // Wraps at n without a modulo operator.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int n);
    return (p == PTR_W'(n - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin priority encoder
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] start_ptr,
  output logic             any,
  output logic [PTR_W-1:0] idx
);

  logic [(1<<PTR_W)-1:0] req_ext;
  logic [PTR_W-1:0]      cand;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    any                  = 1'b0;
    idx                  = '0;
    cand                 = start_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req_ext[cand]) begin
        any = 1'b1;
        idx = cand;
      end
      cand = ptr_inc(cand, N_REQ);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-limited arbiter for the async FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                wclk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                fifo_full,
  output logic                fifo_we,
  output logic [DW-1:0]       fifo_wdata,
  output logic [2:0]          gnt_id,
  output logic                busy,
  output logic [7:0]          wr_count,
  output logic [7:0]          stall_count
);

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt, gnt_nxt;
  logic [BURST_W-1:0]   burst_cnt, burst_nxt;
  logic [CNT_W-1:0]     wr_nxt, stall_nxt;
  logic [(1<<PTR_W)-1:0] valid_ext;
  logic                 valid_g, xfer, pick_any;
  logic [PTR_W-1:0]     pick_idx;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req       (req_valid),
    .start_ptr (rr_ptr),
    .any       (pick_any),
    .idx       (pick_idx)
  );

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt_id      <= '0;
      burst_cnt   <= '0;
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      gnt_id      <= gnt_nxt;
      burst_cnt   <= burst_nxt;
      wr_count    <= wr_nxt;
      stall_count <= stall_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    gnt_nxt    = gnt_id;
    burst_nxt  = burst_cnt;
    wr_nxt     = wr_count;
    stall_nxt  = stall_count;
    fifo_we    = 1'b0;
    fifo_wdata = '0;
    req_ready  = '0;
    busy       = 1'b0;

    valid_ext            = '0;
    valid_ext[N_REQ-1:0] = req_valid;
    valid_g              = valid_ext[gnt_id];
    xfer                 = (state == GRANT) && valid_g && !fifo_full;

    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_nxt   = pick_idx;
          burst_nxt = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        busy    = 1'b1;
        fifo_we = xfer;
        for (int i = 0; i < N_REQ; i++) begin
          if (gnt_id == PTR_W'(i)) begin
            fifo_wdata   = req_data[i*DW +: DW];
            req_ready[i] = xfer;
          end
        end
        if (xfer) begin
          burst_nxt = burst_cnt + 1'b1;
          wr_nxt    = wr_count + 1'b1;
          if (burst_cnt == BURST_W'(MAX_BURST - 1)) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = ptr_inc(gnt_id, N_REQ);
          end
        end else if (!valid_g) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = ptr_inc(gnt_id, N_REQ);
        end else if (stall_count != '1) begin
          // Grantee is blocked only by a full FIFO: hold grant, count the stall.
          stall_nxt = stall_count + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_we;
  logic [3:0]  fifo_wdata;
  logic [2:0]  gnt_id;
  logic        busy;
  logic [7:0]  wr_count;
  logic [7:0]  stall_count;

  int checks = 0;
  int errors = 0;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.N_REQ(4), .DW(4), .MAX_BURST(4)) dut (
    .wclk        (wclk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_we     (fifo_we),
    .fifo_wdata  (fifo_wdata),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .wr_count    (wr_count),
    .stall_count (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge wclk);
  endtask

  task automatic to_next();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    to_next();
    to_next();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_we"}, 32'(fifo_we), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready"}, 32'(req_ready), 0);
  endtask

  task automatic chk_write(input string tag, input int id, input int data);
    chk({tag, "_we"}, 32'(fifo_we), 1);
    chk({tag, "_gnt"}, 32'(gnt_id), 32'(id));
    chk({tag, "_wdata"}, 32'(fifo_wdata), 32'(data));
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
  endtask

  initial begin
    logic [3:0] words [4];
    words[0] = 4'hA; words[1] = 4'hB; words[2] = 4'hC; words[3] = 4'hD;

    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = 16'hDCBA;
    fifo_full = 1'b0;

    // 1. reset state with every requester valid
    to_next();
    to_next();
    to_neg();
    chk_idle("rst");
    chk("rst_wdata", 32'(fifo_wdata), 0);
    chk("rst_gnt", 32'(gnt_id), 0);
    chk("rst_wr_count", 32'(wr_count), 0);
    chk("rst_stall_count", 32'(stall_count), 0);

    // 2. single requester 1
    to_next();
    req_valid = 4'b0010;
    req_data  = 16'h00A0;
    rst       = 1'b0;
    to_neg();
    chk_idle("single_bubble");
    for (int w = 0; w < 4; w++) begin
      to_next();
      to_neg();
      chk_write("single_w", 1, 4'hA);
    end
    to_next();
    to_neg();
    chk_idle("single_release");
    chk("single_wr_count", 32'(wr_count), 4);
    chk("single_gnt_kept", 32'(gnt_id), 1);
    to_next();
    to_neg();
    chk_write("single_regrant", 1, 4'hA);

    // 3. all requesters valid: 5 bursts of 4 in 25 cycles
    to_next();
    req_valid = 4'h0;
    do_reset();
    req_valid = 4'hF;
    req_data  = 16'hDCBA;
    for (int b = 0; b < 5; b++) begin
      to_neg();
      chk_idle("rr_idle");
      for (int w = 0; w < 4; w++) begin
        to_next();
        to_neg();
        chk_write("rr_w", b % 4, int'(words[b % 4]));
      end
      to_next();
    end
    to_neg();
    chk("rr_wr_count", 32'(wr_count), 20);
    chk("rr_stall_count", 32'(stall_count), 0);

    // 4. requester 2 stalled by full FIFO for 3 cycles mid-burst
    req_valid = 4'h0;
    do_reset();
    req_valid = 4'b0100;
    req_data  = 16'h0C00;
    to_neg();
    chk_idle("stall_bubble");
    for (int w = 0; w < 2; w++) begin
      to_next();
      to_neg();
      chk_write("stall_pre", 2, 4'hC);
    end
    to_next();
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      to_neg();
      chk("stall_we", 32'(fifo_we), 0);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_gnt", 32'(gnt_id), 2);
      chk("stall_ready", 32'(req_ready), 0);
      to_next();
    end
    fifo_full = 1'b0;
    for (int w = 0; w < 2; w++) begin
      to_neg();
      chk_write("stall_post", 2, 4'hC);
      to_next();
    end
    to_neg();
    chk_idle("stall_release");
    chk("stall_count", 32'(stall_count), 3);
    chk("stall_wr_count", 32'(wr_count), 4);

    // 5. requester 0 drops valid after 2 writes; next grant scans from 1
    to_next();
    req_valid = 4'h0;
    do_reset();
    req_valid = 4'b1001;
    req_data  = 16'h5006;
    to_neg();
    chk_idle("drop_bubble");
    for (int w = 0; w < 2; w++) begin
      to_next();
      to_neg();
      chk_write("drop_w", 0, 4'h6);
    end
    to_next();
    req_valid = 4'b1000;
    to_neg();
    chk("drop_we", 32'(fifo_we), 0);
    chk("drop_ready", 32'(req_ready), 0);
    to_next();
    req_valid = 4'b1001;
    to_neg();
    chk_idle("drop_idle");
    chk("drop_gnt_kept", 32'(gnt_id), 0);
    chk("drop_wr_count", 32'(wr_count), 2);
    to_next();
    to_neg();
    chk_write("drop_next", 3, 4'h5);

    // 6. rst pulsed mid-burst
    to_next();
    req_valid = 4'h0;
    do_reset();
    req_valid = 4'hF;
    req_data  = 16'hDCBA;
    to_neg();
    chk_idle("mid_bubble");
    for (int w = 0; w < 2; w++) begin
      to_next();
      to_neg();
      chk_write("mid_w", 0, 4'hA);
    end
    to_next();
    to_neg();
    chk("mid_third_we", 32'(fifo_we), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(fifo_we), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_wr_count", 32'(wr_count), 0);
    to_next();
    to_next();
    rst = 1'b0;
    to_neg();
    chk_idle("mid_after_bubble");
    to_next();
    to_neg();
    chk_write("mid_after_w", 0, 4'hA);
    chk("mid_after_wr_count0", 32'(wr_count), 0);
    to_next();
    to_neg();
    chk("mid_after_wr_count1", 32'(wr_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
